// File: rtl/hash_byte_packer.sv
// Packs an Avalon-ST byte stream into 16-bit words for the hash core input.
// Odd-length packets close with a padded word; framing errors are counted and dropped.
module hash_byte_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic        out_empty,
  output logic [7:0]  err_count
);

  // state | meaning
  // LOW   | no byte held; next byte becomes the high byte (or a padded word on EOP)
  // HIGH  | hi_reg holds the high byte of the next word, hi_sop its SOP flag
  typedef enum logic {LOW, HIGH} state_t;

  state_t      state, state_nxt;
  logic [7:0]  hi_reg, hi_nxt;
  logic        hi_sop, hi_sop_nxt;
  logic        in_packet, in_packet_nxt;
  logic        accept;
  logic        err_a, err_b, err_inc;
  logic        load;
  logic [15:0] load_data;
  logic        load_sop, load_eop, load_empty;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign err_a    = in_startofpacket && in_packet;
  assign err_b    = !in_startofpacket && !in_packet;
  assign err_inc  = accept && (err_a || err_b);

  always_comb begin
    state_nxt     = state;
    hi_nxt        = hi_reg;
    hi_sop_nxt    = hi_sop;
    in_packet_nxt = in_packet;
    load          = 1'b0;
    load_data     = out_data;
    load_sop      = out_startofpacket;
    load_eop      = out_endofpacket;
    load_empty    = out_empty;
    if (accept && !err_b) begin
      in_packet_nxt = !in_endofpacket;
      // A restarting SOP byte abandons any held byte and is handled as if from LOW.
      if (state == HIGH && !in_startofpacket) begin
        load       = 1'b1;
        load_data  = {hi_reg, in_data};
        load_sop   = hi_sop;
        load_eop   = in_endofpacket;
        load_empty = 1'b0;
        state_nxt  = LOW;
      end else if (in_endofpacket) begin
        load       = 1'b1;
        load_data  = {in_data, PAD_BYTE};
        load_sop   = in_startofpacket;
        load_eop   = 1'b1;
        load_empty = 1'b1;
        state_nxt  = LOW;
      end else begin
        hi_nxt     = in_data;
        hi_sop_nxt = in_startofpacket;
        state_nxt  = HIGH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOW;
      hi_reg    <= 8'h00;
      hi_sop    <= 1'b0;
      in_packet <= 1'b0;
    end else begin
      state     <= state_nxt;
      hi_reg    <= hi_nxt;
      hi_sop    <= hi_sop_nxt;
      in_packet <= in_packet_nxt;
    end
  end

  // A load is only possible when in_ready, so it may replace a word leaving this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid         <= 1'b0;
      out_data          <= 16'h0000;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= 1'b0;
    end else if (load) begin
      out_valid         <= 1'b1;
      out_data          <= load_data;
      out_startofpacket <= load_sop;
      out_endofpacket   <= load_eop;
      out_empty         <= load_empty;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 8'h00;
    end else if (err_inc && err_count != 8'hFF) begin
      err_count <= err_count + 8'h01;
    end
  end

endmodule
